// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with press and release debounce.
// Drives one active-low column at a time, synchronizes the row lines, and
// emits one key_valid strobe with the key's hex value per physical press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4800,
    parameter int DEBOUNCE_CYCLES = 960_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_hori,
    output logic [3:0] keypad_vert,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    state_t            state, state_n;
    logic [3:0]        sync1, rs;
    logic [1:0]        col, col_n;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
    logic [DB_W-1:0]   db_cnt, db_cnt_n;
    logic [1:0]        cand_row, cand_row_n;
    logic [1:0]        cand_col, cand_col_n;
    logic [3:0]        code_n;
    logic              valid_n;
    logic              held_n;
    logic              one_low;
    logic [1:0]        low_row;
    logic [3:0]        cand_pattern;

    // Hex value printed on the key at (row, col).
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] c);
        logic [3:0] v;
        case ({row, c})
            4'b00_00: v = 4'h1;
            4'b00_01: v = 4'h2;
            4'b00_10: v = 4'h3;
            4'b00_11: v = 4'hA;
            4'b01_00: v = 4'h4;
            4'b01_01: v = 4'h5;
            4'b01_10: v = 4'h6;
            4'b01_11: v = 4'hB;
            4'b10_00: v = 4'h7;
            4'b10_01: v = 4'h8;
            4'b10_10: v = 4'h9;
            4'b10_11: v = 4'hC;
            4'b11_00: v = 4'hE;
            4'b11_01: v = 4'h0;
            4'b11_10: v = 4'hF;
            default:  v = 4'hD;
        endcase
        return v;
    endfunction

    // Only the driven column is low; decoded straight from the column register.
    assign keypad_vert = ~(4'b0001 << col);

    // Row pattern expected while the candidate key alone is pressed.
    assign cand_pattern = ~(4'b0001 << cand_row);

    // Two-flop synchronizer; idle (all rows released) is all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'hF;
            rs    <= 4'hF;
        end else begin
            // NOTE: non-blocking so rs takes sync1's pre-edge value, giving two real flop stages.
            sync1 <= keypad_hori;
            rs    <= sync1;
        end
    end

    // Classify the synchronized rows: exactly one low row, and which one.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        one_low = 1'b1;
        low_row = 2'd0;
        case (rs)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SCAN;
        else        state <= state_n;
    end

    // Next-state logic plus next values of counters, candidate and outputs.
    always_comb begin
        state_n    = state;
        col_n      = col;
        scan_cnt_n = scan_cnt;
        db_cnt_n   = db_cnt;
        cand_row_n = cand_row;
        cand_col_n = cand_col;
        code_n     = key_code;
        valid_n    = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (one_low) begin
                        // Freeze the column and start debouncing this key.
                        cand_row_n = low_row;
                        cand_col_n = col;
                        db_cnt_n   = '0;
                        state_n    = PRESS_DB;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end
            PRESS_DB: begin
                if (rs == cand_pattern) begin
                    if (db_cnt == DB_LAST) begin
                        valid_n = 1'b1;
                        code_n  = key_map(cand_row, cand_col);
                        state_n = HELD;
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end else begin
                    // Bounce or second key: resume scanning after this column.
                    state_n    = SCAN;
                    col_n      = cand_col + 2'd1;
                    scan_cnt_n = '0;
                end
            end
            HELD: begin
                // Other rows are ignored; only the accepted key's row matters.
                if (rs[cand_row]) begin
                    db_cnt_n = '0;
                    state_n  = REL_DB;
                end
            end
            REL_DB: begin
                if (rs == 4'hF) begin
                    if (db_cnt == DB_LAST) begin
                        state_n    = SCAN;
                        col_n      = cand_col + 2'd1;
                        scan_cnt_n = '0;
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end else begin
                    state_n = HELD;
                end
            end
            default: state_n = SCAN;
        endcase
        held_n = (state_n == HELD) || (state_n == REL_DB);
    end

    // Datapath registers: column, counters, candidate key and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= 2'd0;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col       <= col_n;
            scan_cnt  <= scan_cnt_n;
            db_cnt    <= db_cnt_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] keypad_hori;
    logic [3:0] keypad_vert;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // pressed[row*4+col] = 1 while that key is physically down
    logic [15:0] pressed;

    int         n_checks;
    int         n_pass;
    int         strobe_count;
    logic [3:0] last_code;
    int         base;
    bit         ok;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keypad_hori(keypad_hori),
        .keypad_vert(keypad_vert),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        keypad_hori = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keypad_vert[c]) keypad_hori[r] = 1'b0;
    end

    // Count every cycle key_valid is high and remember the code seen with it.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            strobe_count = strobe_count + 1;
            last_code    = key_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return at the first negedge on which the given column has just become driven.
    task automatic wait_col_entry(input logic [3:0] target, output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = keypad_vert;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (keypad_vert == target && prev != target) begin
                found = 1'b1;
                break;
            end
            prev = keypad_vert;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        strobe_count = 0;
        last_code    = 4'h0;
        pressed      = '0;
        reset        = 1'b0;

        // Reset and idle rotation
        tick(3);
        check("rst_vert",  keypad_vert, 4'b1110);
        check("rst_code",  key_code,    4'h0);
        check("rst_valid", key_valid,   1'b0);
        check("rst_held",  key_held,    1'b0);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_v;
            exp_v = ~(4'b0001 << (k / 4));
            #1 check($sformatf("rotate_%0d", k), keypad_vert, exp_v);
            @(negedge clk);
        end

        // Clean press '5' (row 1, column 1)
        base = strobe_count;
        pressed[1*4+1] = 1'b1;
        tick(40);
        check("p5_strobes", strobe_count - base, 1);
        check("p5_strobe_code", last_code, 4'h5);
        check("p5_code", key_code, 4'h5);
        check("p5_held", key_held, 1'b1);
        pressed = '0;
        tick(8);
        check("p5_held_rel8", key_held, 1'b1);
        tick(4);
        check("p5_held_rel12", key_held, 1'b0);
        check("p5_strobes_after", strobe_count - base, 1);

        // Bounce on '9' (row 2, column 2) during press debounce
        base = strobe_count;
        wait_col_entry(4'b1011, ok);
        check("p9_entry", ok, 1'b1);
        pressed[2*4+2] = 1'b1;
        tick(6);
        pressed[2*4+2] = 1'b0;
        tick(1);
        pressed[2*4+2] = 1'b1;
        tick(6);
        check("p9_no_early_strobe", strobe_count - base, 0);
        check("p9_not_held", key_held, 1'b0);
        tick(40);
        check("p9_strobes", strobe_count - base, 1);
        check("p9_code", key_code, 4'h9);
        pressed = '0;
        tick(20);
        check("p9_released", key_held, 1'b0);

        // Two rows low in column 1 ('2' and '0'): rejected, scanning continues
        base = strobe_count;
        wait_col_entry(4'b1101, ok);
        check("multi_entry", ok, 1'b1);
        pressed[0*4+1] = 1'b1;
        pressed[3*4+1] = 1'b1;
        tick(4);
        check("multi_rotates", keypad_vert, 4'b1011);
        tick(36);
        check("multi_strobes", strobe_count - base, 0);
        check("multi_held", key_held, 1'b0);
        check("multi_code", key_code, 4'h9);
        pressed = '0;
        tick(4);

        // 'A' with a release glitch, then '0'
        base = strobe_count;
        wait_col_entry(4'b0111, ok);
        check("pA_entry", ok, 1'b1);
        pressed[0*4+3] = 1'b1;
        tick(20);
        check("pA_strobes", strobe_count - base, 1);
        check("pA_code", key_code, 4'hA);
        check("pA_held", key_held, 1'b1);
        pressed = '0;
        tick(5);
        pressed[0*4+3] = 1'b1;
        tick(2);
        pressed = '0;
        tick(5);
        check("pA_glitch_held", key_held, 1'b1);
        tick(10);
        check("pA_released", key_held, 1'b0);
        check("pA_no_restrobe", strobe_count - base, 1);
        wait_col_entry(4'b1101, ok);
        check("p0_entry", ok, 1'b1);
        pressed[3*4+1] = 1'b1;
        tick(20);
        check("p0_strobes_total", strobe_count - base, 2);
        check("p0_code", key_code, 4'h0);
        pressed = '0;
        tick(20);
        check("p0_released", key_held, 1'b0);

        // Reset pulse while 'D' is held
        wait_col_entry(4'b0111, ok);
        check("pD_entry", ok, 1'b1);
        pressed[3*4+3] = 1'b1;
        tick(20);
        check("pD_code", key_code, 4'hD);
        check("pD_held", key_held, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_vert",  keypad_vert, 4'b1110);
        check("midrst_code",  key_code,    4'h0);
        check("midrst_valid", key_valid,   1'b0);
        check("midrst_held",  key_held,    1'b0);
        @(negedge clk);
        reset = 1'b1;
        base = strobe_count;
        tick(40);
        check("pD2_strobes", strobe_count - base, 1);
        check("pD2_code", key_code, 4'hD);
        check("pD2_held", key_held, 1'b1);
        pressed = '0;
        tick(20);
        check("pD2_released", key_held, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
